store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the pipeline memory stage and the shared data bus (ABUS/DBUS/WE/LOCK) that feeds DataMemory and the IO devices.
- Stores retire into a small FIFO and drain to the bus in cycles the pipeline does not need the bus for a load.
- Loads forward from buffered stores on a word-address match.
- IO loads and fences wait for the buffer to empty, which preserves ordering.

Parameters:
- ADDR_BIT_WIDTH, 32, address width of pipeline and bus.
- DATA_BIT_WIDTH, 32, data width.
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- IO_SEL_BIT, 28, address bit that selects IO space (1) versus memory (0).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- ST_REQ  input  1  pipeline store request this cycle.
- LD_REQ  input  1  pipeline load request this cycle.
- FENCE_REQ  input  1  pipeline requests all buffered stores be drained.
- ADDR_IN  input  ADDR_BIT_WIDTH  byte address of load/store; bits [1:0] ignored.
- WDATA_IN  input  DATA_BIT_WIDTH  store data.
- RDATA_OUT  output  DATA_BIT_WIDTH  load result; valid in the same cycle as LD_REQ when STALL=0.
- STALL  output  1  pipeline must hold its current request.
- ABUS  output  ADDR_BIT_WIDTH  bus address.
- DBUS  inout  DATA_BIT_WIDTH  bus data; driven only during a drain write, otherwise high-Z.
- WE  output  1  bus write enable.
- LOCK  output  1  bus write commit strobe; high exactly in drain-write cycles.

Behaviour:
- Storage: circular FIFO of DEPTH entries {word address ADDR_IN[ADDR_BIT_WIDTH-1:2], data}, with head/tail pointers and a count 0..DEPTH.
- Reset (async): count=0, pointers=0, state=NORMAL. Outputs: STALL=0, WE=0, LOCK=0, ABUS=0, DBUS=Z, RDATA_OUT=0. Entries present at reset are discarded; a partially committed drain is abandoned.
- Word match: the load word address equals an entry's word address. When several entries match, the youngest (nearest tail) wins.
- Bus arbitration, decided combinationally each cycle:
  - Bus load: LD_REQ=1, no forwarding hit, STALL=0. Drive ABUS=ADDR_IN, WE=0, LOCK=0, DBUS=Z; RDATA_OUT=DBUS.
  - Forwarding hit: RDATA_OUT=matching entry data. The bus is free and may drain in the same cycle.
  - Drain: count>0 and the bus is not used by a load. Drive ABUS={head addr,2'b00}, WE=1, LOCK=1, DBUS=head data; head pops at posedge.
  - Otherwise the bus is idle: ABUS=0, WE=0, LOCK=0, DBUS=Z.
- Store acceptance: store ST_REQ&&!STALL at tail on posedge.
  - count<DEPTH: accepted.
  - count==DEPTH: a drain is guaranteed that cycle (stores never share a cycle with loads), so push and pop happen simultaneously and count stays DEPTH. No stall.
- Forward/drain overlap: a hit on the head entry being drained in the same cycle still forwards that entry's data.
- IO load ordering: LD_REQ with ADDR_IN[IO_SEL_BIT]=1 and count>0 gives STALL=1; the buffer drains.
  - Next cycle with count==0: STALL=0 and the load proceeds on the bus.
  - IO loads never forward.
- FSM NORMAL/FENCE:
  - NORMAL→FENCE on FENCE_REQ with count>0; STALL=1 in that cycle.
  - In FENCE: STALL=1, drain every cycle, ST_REQ/LD_REQ ignored.
  - FENCE→NORMAL on the posedge where count goes 1→0. STALL drops in the following cycle.
  - FENCE_REQ with count==0 is a no-op with no stall.
- Illegal input ST_REQ&&LD_REQ: the load is serviced, the store is not accepted, and STALL=1 until the pipeline drops one request.
- Pointer wrap: pointers wrap modulo DEPTH. count is DEPTH-width+1 bits, so full and empty are distinct.
- Latency:
  - Store visible to forwarding from the cycle after acceptance.
  - Memory updated at the posedge ending its drain cycle.
  - At least count+1 cycles after acceptance when no loads intervene.

Test Plan:
1. Reset: RESET=1 mid-drain with count=3 → immediately WE=0, LOCK=0, DBUS=Z, STALL=0. After release, load to 0x40 reads memory, not the stale entry.
2. Store 0xDEADBEEF@0x100, next cycle load 0x102 → RDATA_OUT=0xDEADBEEF, no bus read. The drain of 0x100 occurs in that same cycle with WE=1, LOCK=1.
3. Stores 0x11@0x20, then 0x22@0x20, with back-to-back loads blocking drains; load 0x20 → 0x22 (youngest wins). After the drains, memory[0x20]=0x22.
4. Fill to DEPTH=4 under continuous loads, then a 5th store → no STALL; same-cycle push/pop keeps count=4; FIFO order is preserved on drain.
5. count=2, IO load 0x10000000 → STALL=1 for 2 cycles while 2 drains occur. Then STALL=0 and ABUS=0x10000000, WE=0.
6. count=3, FENCE_REQ → STALL=1 for exactly 3 cycles with 3 consecutive drain writes. Returns to NORMAL; FENCE_REQ at count=0 → no STALL.

Source files
------------

// File: rtl/store_buffer_if.sv
// store_buffer_if: pipeline request/response and bus control signals of the store buffer
interface store_buffer_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
);
  logic                      ST_REQ;
  logic                      LD_REQ;
  logic                      FENCE_REQ;
  logic [ADDR_BIT_WIDTH-1:0] ADDR_IN;
  logic [DATA_BIT_WIDTH-1:0] WDATA_IN;
  logic [DATA_BIT_WIDTH-1:0] RDATA_OUT;
  logic                      STALL;
  logic [ADDR_BIT_WIDTH-1:0] ABUS;
  logic                      WE;
  logic                      LOCK;
  modport master (
    output ST_REQ, LD_REQ, FENCE_REQ, ADDR_IN, WDATA_IN,
    input  RDATA_OUT, STALL, ABUS, WE, LOCK
  );
  modport slave (
    input  ST_REQ, LD_REQ, FENCE_REQ, ADDR_IN, WDATA_IN,
    output RDATA_OUT, STALL, ABUS, WE, LOCK
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO draining to the shared bus, with load forwarding and fence/IO ordering
module store_buffer #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int DEPTH          = 4,
  parameter int IO_SEL_BIT     = 28
) (
  input  logic                      CLK,
  input  logic                      RESET,
  store_buffer_if.slave             bus,
  inout  wire  [DATA_BIT_WIDTH-1:0] DBUS
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_BIT_WIDTH - 2;
  typedef enum logic {NORMAL, FENCE} state_t;
  state_t                    state_q, state_d;
  logic [WW-1:0]             addr_q [DEPTH];
  logic [DATA_BIT_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]             head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0]             count_q, count_d;
  logic                      io_ld, fence_wait, io_wait, ld_srv, hit, fwd, bus_ld, drain, push, stall;
  logic [DATA_BIT_WIDTH-1:0] hit_data, rdata;
  logic [ADDR_BIT_WIDTH-1:0] abus;
  // Oldest to youngest, so the last match (youngest) wins
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q && addr_q[idx] == bus.ADDR_IN[ADDR_BIT_WIDTH-1:2]) begin
        hit = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end
  always_comb begin
    io_ld = bus.ADDR_IN[IO_SEL_BIT];
    fence_wait = state_q == FENCE || (bus.FENCE_REQ && count_q != '0);
    io_wait = bus.LD_REQ && io_ld && count_q != '0;
    ld_srv = bus.LD_REQ && !fence_wait && !io_wait;
    fwd = ld_srv && hit && !io_ld;
    bus_ld = ld_srv && !fwd;
    drain = count_q != '0 && !bus_ld;
    push = bus.ST_REQ && !stall;
    head_d = head_q + PW'(drain);
    tail_d = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(drain);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= NORMAL;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail_q] <= bus.ADDR_IN[ADDR_BIT_WIDTH-1:2];
      data_q[tail_q] <= bus.WDATA_IN;
    end
  end
  // Leave FENCE on the edge that empties the buffer
  always_comb state_d = (fence_wait && count_d != '0) ? FENCE : NORMAL;
  always_comb begin
    stall = fence_wait || io_wait || (bus.ST_REQ && bus.LD_REQ);
    abus = bus_ld ? bus.ADDR_IN : drain ? {addr_q[head_q], 2'b00} : '0;
    rdata = bus_ld ? DBUS : fwd ? hit_data : '0;
  end
  assign bus.STALL = stall;
  assign bus.ABUS = abus;
  assign bus.WE = drain;
  assign bus.LOCK = drain;
  assign bus.RDATA_OUT = rdata;
  assign DBUS = drain ? data_q[head_q] : 'z;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus against a queue-based model of the store buffer
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  wire [31:0] dbus;
  store_buffer_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) sb_if ();
  store_buffer #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32), .DEPTH(4), .IO_SEL_BIT(28)) dut (
    .CLK(clk), .RESET(rst), .bus(sb_if), .DBUS(dbus)
  );
  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 | 32'(i);
  endfunction
  function automatic logic [31:0] io_word(logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction
  logic [31:0] mem [256];
  logic [31:0] mem_rd;
  always_comb mem_rd = sb_if.ABUS[28] ? io_word(sb_if.ABUS) : mem[sb_if.ABUS[9:2]];
  assign dbus = (sb_if.LD_REQ && !sb_if.WE) ? mem_rd : 'z;
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    else if (sb_if.WE && !sb_if.ABUS[28]) mem[sb_if.ABUS[9:2]] <= dbus;
  end
  typedef struct packed {logic [29:0] a; logic [31:0] d;} ent_t;
  ent_t        q[$];
  bit          m_fence;
  logic [31:0] refmem [256];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] o_rdata, o_abus;
  logic        o_stall, o_we;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_fence = 1'b0;
    for (int i = 0; i < 256; i++) refmem[i] = init_word(i);
  endtask
  task automatic drive(input logic st, ld, fn, input logic [31:0] a, wd);
    sb_if.ST_REQ = st;
    sb_if.LD_REQ = ld;
    sb_if.FENCE_REQ = fn;
    sb_if.ADDR_IN = a;
    sb_if.WDATA_IN = wd;
  endtask
  // One pipeline cycle: drive, compare against the model, then advance the model past the posedge
  task automatic cycle(input logic st, ld, fn, input logic [31:0] a, wd);
    int cnt;
    bit fw, iow, e_stall, srv, hit, bl, dr;
    logic [31:0] hd, e_abus, e_rd;
    ent_t e;
    @(negedge clk);
    drive(st, ld, fn, a, wd);
    #1;
    cnt = q.size();
    fw = m_fence || (fn && cnt > 0);
    iow = ld && a[28] && cnt > 0;
    e_stall = fw || iow || (st && ld);
    srv = ld && !fw && !iow;
    hit = 1'b0;
    hd = '0;
    if (srv && !a[28])
      for (int i = cnt - 1; i >= 0; i--)
        if (q[i].a == a[31:2]) begin
          hit = 1'b1;
          hd = q[i].d;
          break;
        end
    bl = srv && !hit;
    dr = cnt > 0 && !bl;
    e_abus = bl ? a : dr ? {q[0].a, 2'b00} : 32'h0;
    e_rd = bl ? (a[28] ? io_word(a) : refmem[a[9:2]]) : hit ? hd : 32'h0;
    o_stall = sb_if.STALL;
    o_we = sb_if.WE;
    o_abus = sb_if.ABUS;
    o_rdata = sb_if.RDATA_OUT;
    chk("stall", {31'b0, o_stall}, {31'b0, e_stall});
    chk("we", {31'b0, o_we}, {31'b0, dr});
    chk("lock", {31'b0, sb_if.LOCK}, {31'b0, dr});
    chk("abus", o_abus, e_abus);
    chk("rdata", o_rdata, e_rd);
    if (dr) begin
      if (!q[0].a[26]) refmem[q[0].a[7:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (st && !e_stall) begin
      e.a = a[31:2];
      e.d = wd;
      q.push_back(e);
    end
    m_fence = fw && q.size() > 0;
  endtask
  initial begin
    logic [31:0] ra;
    bit rst_st, rst_ld, rst_fn;
    int r;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rst_stall", {31'b0, sb_if.STALL}, 32'h0);
    chk("rst_we", {31'b0, sb_if.WE}, 32'h0);
    chk("rst_abus", sb_if.ABUS, 32'h0);
    chk("rst_rdata", sb_if.RDATA_OUT, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Reset while a drain is on the bus abandons it
    cycle(1, 0, 0, 32'h40, 32'hBAD0_BAD0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_we", {31'b0, sb_if.WE}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we", {31'b0, sb_if.WE}, 32'h0);
    chk("mid_rst_lock", {31'b0, sb_if.LOCK}, 32'h0);
    chk("mid_rst_stall", {31'b0, sb_if.STALL}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 1, 0, 32'h40, 0);
    chk("t1_stale", o_rdata, init_word(16));
    // Forwarding hit drains the same entry in the same cycle
    cycle(1, 0, 0, 32'h100, 32'hDEAD_BEEF);
    cycle(0, 1, 0, 32'h102, 0);
    chk("t2_fwd", o_rdata, 32'hDEAD_BEEF);
    chk("t2_we", {31'b0, o_we}, 32'h1);
    chk("t2_abus", o_abus, 32'h100);
    // Youngest entry wins, memory ends with the youngest value
    cycle(1, 0, 0, 32'h20, 32'h11);
    cycle(1, 0, 0, 32'h20, 32'h22);
    cycle(0, 1, 0, 32'h20, 0);
    chk("t3_young", o_rdata, 32'h22);
    cycle(0, 1, 0, 32'h20, 0);
    chk("t3_mem", o_rdata, 32'h22);
    // Back-to-back stores never stall, FIFO order preserved
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 32'h80 + 32'(i * 4), 32'h5000 + 32'(i));
      chk("t4_nostall", {31'b0, o_stall}, 32'h0);
    end
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 32'h80 + 32'(i * 4), 0);
      chk("t4_order", o_rdata, 32'h5000 + 32'(i));
    end
    // IO load waits for the buffer to empty
    cycle(1, 0, 0, 32'h30, 32'h3333);
    cycle(0, 1, 0, 32'h1000_0000, 0);
    chk("t5_iostall", {31'b0, o_stall}, 32'h1);
    cycle(0, 1, 0, 32'h1000_0000, 0);
    chk("t5_iogo", {31'b0, o_stall}, 32'h0);
    chk("t5_ioabus", o_abus, 32'h1000_0000);
    chk("t5_iowe", {31'b0, o_we}, 32'h0);
    // Fence stalls while draining, no-op when empty
    cycle(1, 0, 0, 32'h34, 32'h4444);
    cycle(0, 0, 1, 0, 0);
    chk("t6_fstall", {31'b0, o_stall}, 32'h1);
    cycle(0, 0, 1, 0, 0);
    chk("t6_fdone", {31'b0, o_stall}, 32'h0);
    // Simultaneous store and load: load serviced, store dropped
    cycle(1, 1, 0, 32'h50, 32'h7777);
    chk("t7_illegal", {31'b0, o_stall}, 32'h1);
    cycle(0, 1, 0, 32'h50, 0);
    chk("t7_nostore", o_rdata, init_word(20));
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 15));
      rst_st = r < 6 || r == 15;
      rst_ld = (r >= 6 && r < 12) || r == 15;
      rst_fn = r == 12 || r == 13 || ($urandom_range(0, 9) == 0);
      ra = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if (rst_ld && !rst_st && $urandom_range(0, 5) == 0) ra = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2);
      cycle(rst_st, rst_ld, rst_fn, ra, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
